// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for a Galois LFSR word stream.
// It hunts for LOCK_COUNT consecutive valid transitions, then flywheels a local
// predictor and counts word and bit errors with saturating counters.
module prbs_checker #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'b1000000001011,
  parameter bit               INVERT     = 1'b0,
  parameter int unsigned      LOCK_COUNT = 8,
  parameter int unsigned      LOSS_COUNT = 4,
  parameter int unsigned      CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     data,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] bit_err_count
);

  localparam int unsigned MR_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned ML_W  = $clog2(LOSS_COUNT + 1);
  localparam int unsigned PC_W  = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic                  have_prev_q, have_prev_d;
  logic [WIDTH-1:0]      pred_q, pred_d;
  logic [MR_W-1:0]       match_run_q, match_run_d;
  logic [ML_W-1:0]       miss_run_q, miss_run_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [CNT_WIDTH-1:0]  bit_err_count_q, bit_err_count_d;

  logic                  word_inc;
  logic [PC_W-1:0]       bit_inc;
  logic [MR_W-1:0]       match_run_inc;
  logic [ML_W-1:0]       miss_run_inc;

  // One step of the Galois recurrence shared with the generator.
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = {x[WIDTH-2:0], 1'b0};
    if (x[WIDTH-1] ^ INVERT) begin
      r = r ^ TAPS;
    end
    return r;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] x);
    logic [PC_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + PC_W'(x[i]);
    end
    return n;
  endfunction

  // Add in a wider domain so a large bit increment on a narrow counter clamps
  // instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                   input logic [PC_W-1:0]      inc);
    logic [SUM_W-1:0]     sum;
    logic [CNT_WIDTH-1:0] r;
    sum = SUM_W'(base) + SUM_W'(inc);
    if (sum > SUM_W'({CNT_WIDTH{1'b1}})) begin
      r = '1;
    end else begin
      r = sum[CNT_WIDTH-1:0];
    end
    return r;
  endfunction

  // Next-state: hunt/lock FSM, run lengths, predictor and error counters.
  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    have_prev_d   = have_prev_q;
    pred_d        = pred_q;
    match_run_d   = match_run_q;
    miss_run_d    = miss_run_q;
    err_d         = 1'b0;
    word_inc      = 1'b0;
    bit_inc       = '0;
    match_run_inc = match_run_q + 1'b1;
    miss_run_inc  = miss_run_q + 1'b1;

    if (valid) begin
      unique case (state_q)
        HUNT: begin
          if (have_prev_q && (data == nxt(prev_q)) && (data != '0)) begin
            match_run_d = match_run_inc;
          end else begin
            match_run_d = '0;
          end
          prev_d      = data;
          have_prev_d = 1'b1;
          if (match_run_d == MR_W'(LOCK_COUNT)) begin
            state_d     = LOCKED;
            pred_d      = nxt(data);
            miss_run_d  = '0;
            match_run_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the predictor advances regardless of the comparison so
          // a single corrupted word costs exactly one error.
          pred_d = nxt(pred_q);
          if (data != pred_q) begin
            err_d      = 1'b1;
            word_inc   = 1'b1;
            bit_inc    = popcount(data ^ pred_q);
            miss_run_d = miss_run_inc;
            if (miss_run_inc == ML_W'(LOSS_COUNT)) begin
              // Re-acquisition starts from the word that broke lock.
              state_d     = HUNT;
              match_run_d = '0;
              prev_d      = data;
              have_prev_d = 1'b1;
            end
          end else begin
            miss_run_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear drops old content but keeps this cycle's increment.
    err_count_d     = sat_add(clear ? '0 : err_count_q, PC_W'(word_inc));
    bit_err_count_d = sat_add(clear ? '0 : bit_err_count_q, bit_inc);
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= HUNT;
      prev_q          <= '0;
      have_prev_q     <= 1'b0;
      pred_q          <= '0;
      match_run_q     <= '0;
      miss_run_q      <= '0;
      err_q           <= 1'b0;
      err_count_q     <= '0;
      bit_err_count_q <= '0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      have_prev_q     <= have_prev_d;
      pred_q          <= pred_d;
      match_run_q     <= match_run_d;
      miss_run_q      <= miss_run_d;
      err_q           <= err_d;
      err_count_q     <= err_count_d;
      bit_err_count_q <= bit_err_count_d;
    end
  end

  assign locked        = (state_q == LOCKED);
  assign err           = err_q;
  assign err_count     = err_count_q;
  assign bit_err_count = bit_err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: stimulus pushes expected outputs, a
// monitor pops and compares one cycle after each edge. A second instance with
// 4-bit counters shares the stimulus to exercise saturation.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic        clear = 1'b0;
  logic        locked, err, locked4, err4;
  logic [31:0] err_count, bit_err_count;
  logic [3:0]  err_count4, bit_err_count4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic            lk;
    logic            er;
    longint unsigned ec;
    longint unsigned bc;
    longint unsigned ec4;
    longint unsigned bc4;
  } exp_t;
  exp_t sb[$];

  // Reference state of the checker behaviour.
  logic            m_locked, m_have;
  logic [15:0]     m_prev, m_pred;
  int              m_match, m_miss;
  longint unsigned m_ec, m_bc, m_ec4, m_bc4;

  logic [15:0] g;

  prbs_checker dut (
    .clk(clk), .reset(reset), .valid(valid), .data(data), .clear(clear),
    .locked(locked), .err(err), .err_count(err_count), .bit_err_count(bit_err_count)
  );

  prbs_checker #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .valid(valid), .data(data), .clear(clear),
    .locked(locked4), .err(err4), .err_count(err_count4), .bit_err_count(bit_err_count4)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr(input logic [15:0] x);
    logic [15:0] r;
    r = {x[14:0], 1'b0};
    if (x[15]) r = r ^ 16'h100B;
    return r;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_prev = '0; m_pred = '0;
    m_match = 0; m_miss = 0; m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue its expectation.
  task automatic step(input logic v, input logic [15:0] d, input logic c);
    exp_t e;
    longint unsigned winc, binc;
    @(negedge clk);
    valid = v; data = d; clear = c;
    winc = 0; binc = 0; e.er = 0;
    if (v) begin
      if (!m_locked) begin
        if (m_have && d == lfsr(m_prev) && d != 16'h0) m_match++;
        else m_match = 0;
        m_prev = d; m_have = 1;
        if (m_match == 8) begin
          m_locked = 1; m_pred = lfsr(d); m_miss = 0; m_match = 0;
        end
      end else begin
        if (d != m_pred) begin
          e.er = 1; winc = 1; binc = $countones(d ^ m_pred); m_miss++;
          if (m_miss == 4) begin
            m_locked = 0; m_match = 0; m_prev = d; m_have = 1;
          end
        end else begin
          m_miss = 0;
        end
        m_pred = lfsr(m_pred);
      end
    end
    m_ec  = (c ? 0 : m_ec) + winc;   if (m_ec  > 64'hFFFF_FFFF) m_ec  = 64'hFFFF_FFFF;
    m_bc  = (c ? 0 : m_bc) + binc;   if (m_bc  > 64'hFFFF_FFFF) m_bc  = 64'hFFFF_FFFF;
    m_ec4 = (c ? 0 : m_ec4) + winc;  if (m_ec4 > 15) m_ec4 = 15;
    m_bc4 = (c ? 0 : m_bc4) + binc;  if (m_bc4 > 15) m_bc4 = 15;
    e.lk = m_locked; e.ec = m_ec; e.bc = m_bc; e.ec4 = m_ec4; e.bc4 = m_bc4;
    sb.push_back(e);
  endtask

  // Wait for the edge that consumes the last step, then settle.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Called only after after_edge, so no expectation is outstanding.
  task automatic do_reset();
    valid = 0; clear = 0; reset = 1;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_bit_err_count", bit_err_count, 0);
    chk("rst_err_count4", err_count4, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  // Monitor: compare every queued expectation one time unit after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("mon_locked", locked, e.lk);
        chk("mon_err", err, e.er);
        chk("mon_err_count", err_count, e.ec);
        chk("mon_bit_err_count", bit_err_count, e.bc);
        chk("mon_err_count4", err_count4, e.ec4);
        chk("mon_bit_err_count4", bit_err_count4, e.bc4);
      end
    end
  end

  initial begin
    int acc;
    int iter;
    bit seen;
    model_reset();
    #1;
    chk("init_locked", locked, 0);
    chk("init_err_count", err_count, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    // Acquisition from seed 1: w0 seeds, w1..w8 are the 8 transitions.
    g = 16'h0001;
    for (int i = 0; i < 9; i++) begin
      step(1, g, 0);
      g = lfsr(g);
      after_edge();
      chk(i < 8 ? "lock_early" : "lock_at_w8", locked, i < 8 ? 0 : 1);
    end
    for (int i = 0; i < 1000; i++) begin
      step(1, g, 0);
      g = lfsr(g);
    end
    after_edge();
    chk("clean_err_count", err_count, 0);
    chk("clean_bit_err_count", bit_err_count, 0);

    // Single bit-3 corruption.
    step(1, g ^ 16'h0008, 0);
    g = lfsr(g);
    after_edge();
    chk("single_err_pulse", err, 1);
    chk("single_err_count", err_count, 1);
    chk("single_bit_err_count", bit_err_count, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, g, 0);
      g = lfsr(g);
    end
    after_edge();
    chk("single_no_second", err_count, 1);
    chk("single_still_locked", locked, 1);

    // Clear, then four fully inverted words drop lock.
    step(1, g, 1);
    g = lfsr(g);
    for (int i = 0; i < 4; i++) begin
      step(1, g ^ 16'hFFFF, 0);
      g = lfsr(g);
      after_edge();
      chk(i < 3 ? "loss_hold" : "loss_drop", locked, i < 3 ? 1 : 0);
    end
    chk("loss_err_count", err_count, 4);
    chk("loss_bit_err_count", bit_err_count, 64);
    for (int i = 0; i < 9; i++) begin
      step(1, g, 0);
      g = lfsr(g);
      after_edge();
      chk(i < 8 ? "relock_early" : "relock", locked, i < 8 ? 0 : 1);
    end

    // Random valid gaps: lock still on the 9th accepted word.
    do_reset();
    g = 16'h0001; acc = 0; seen = 0; iter = 0;
    while (acc < 200 && iter < 2000) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      step(v, v ? g : 16'hDEAD, 0);
      if (v) begin g = lfsr(g); acc++; end
      iter++;
      after_edge();
      if (acc < 9) chk("gap_no_lock", locked, 0);
      else if (!seen) begin chk("gap_lock_at_9", locked, 1); seen = 1; end
    end
    chk("gap_accepted", acc, 200);
    chk("gap_err_count", err_count, 0);
    chk("gap_bit_err_count", bit_err_count, 0);

    // All-zero stream never locks.
    do_reset();
    for (int i = 0; i < 30; i++) step(1, 16'h0000, 0);
    after_edge();
    chk("zero_no_lock", locked, 0);

    // Alternating clean/corrupt while locked: 20 errors, 4-bit counters pin at 15.
    do_reset();
    g = 16'h0001;
    for (int i = 0; i < 9; i++) begin
      step(1, g, 0);
      g = lfsr(g);
    end
    for (int i = 0; i < 40; i++) begin
      step(1, (i % 2 == 1) ? (g ^ 16'h0001) : g, 0);
      g = lfsr(g);
    end
    after_edge();
    chk("sat_err_count4", err_count4, 15);
    chk("sat_bit_err_count4", bit_err_count4, 15);
    chk("sat_locked4", locked4, 1);
    chk("sat_err_count", err_count, 20);
    chk("sat_bit_err_count", bit_err_count, 20);

    // Clear coincident with an error keeps that error.
    step(1, g ^ 16'h0002, 1);
    g = lfsr(g);
    after_edge();
    chk("clear_coincident", err_count, 1);
    chk("clear_coincident_bits", bit_err_count, 1);
    chk("clear_keeps_lock", locked, 1);

    // Asynchronous reset between edges while locked.
    step(1, g, 0);
    g = lfsr(g);
    after_edge();
    #2;
    do_reset();

    step(0, 16'h0000, 0);
    after_edge();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
